mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch (IF) stage and the data-access (MEM) stage of the pipelined CPU.
- Accepts level-held requests from both stages and grants one at a time, with data priority and an IF anti-starvation rule.
- Drives the memory request/ready handshake and returns read data with a one-cycle ack.
- Flags misaligned word addresses as errors without touching memory, so the controller can raise an exception.

---
 rtl/cpu_mem_pkg.sv | 29 ++
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the IF/MEM unified-memory arbiter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Word accesses must have these address bits clear.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Latched per-grant control: who owns the port, store flag, alignment fault.
  typedef struct packed {
    owner_e owner;
    logic   we;
    logic   err;
  } grant_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: data has priority unless IF has already lost STARVE_MAX
// consecutive grants while it was waiting.
module mem_arb_pick
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 2
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_valid,
  output owner_e           grant_owner
);

  // Priority rule with IF anti-starvation override.
  always_comb begin
    grant_valid = if_req | d_req;
    grant_owner = OWN_IF;
    if (d_req && (!if_req || (starve_cnt < CNT_W'(STARVE_MAX))))
      grant_owner = OWN_D;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// One transaction at a time: IDLE picks and latches, BUSY holds the memory
// handshake, RESP pulses the owner's ack for one cycle.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  grant_t            grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic              pick_valid;
  owner_e            pick_owner;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_err;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .starve_cnt  (starve_q),
    .grant_valid (pick_valid),
    .grant_owner (pick_owner)
  );

  // Next-state: grant/latch in IDLE, wait for memory in BUSY, ack in RESP.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_req_d  = mem_req_q;
    starve_d   = starve_q;
    sel_addr   = (pick_owner == OWN_D) ? d_addr : if_addr;
    sel_err    = is_misaligned(sel_addr[1:0]);

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d.owner = pick_owner;
          grant_d.we    = (pick_owner == OWN_D) & d_we;
          grant_d.err   = sel_err;
          addr_d        = sel_addr;
          wdata_d       = (pick_owner == OWN_D) ? d_wdata : '0;
          if (pick_owner == OWN_IF)
            starve_d = '0;
          else if (if_req && (starve_q < CNT_W'(STARVE_MAX)))
            starve_d = starve_q + CNT_W'(1);
          // Misaligned grants skip memory entirely and report straight away.
          if (sel_err) begin
            state_d = RESP;
          end else begin
            state_d   = BUSY;
            mem_req_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (grant_q.owner == OWN_IF)
            if_rdata_d = mem_rdata;
          else
            d_rdata_d = grant_q.we ? '0 : mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '{owner: OWN_IF, we: 1'b0, err: 1'b0};
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      mem_req_q  <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      mem_req_q  <= mem_req_d;
      starve_q   <= starve_d;
    end
  end

  assign if_ack    = (state_q == RESP) && (grant_q.owner == OWN_IF);
  assign d_ack     = (state_q == RESP) && (grant_q.owner == OWN_D);
  assign if_err    = if_ack & grant_q.err;
  assign d_err     = d_ack & grant_q.err;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_req_q & grant_q.we;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level model:
// the bench plays both requesters and the memory, predicts each winner,
// memory beat and ack from the arbitration rules and a shadow memory.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_ack, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_ack, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stall_if, stall_mem;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] memarr [16];  // the memory the DUT actually drives
  logic [31:0] shadow [16];  // what memory must contain by the rules
  int          mcnt;         // data wins in a row while IF waited
  logic [31:0] exp_ifr, exp_dr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr(input bit allow_mis);
    logic [31:0] a;
    a = $urandom;
    a[1:0] = (allow_mis && ($urandom_range(0, 7) == 0)) ? 2'($urandom_range(1, 3)) : 2'b00;
    return a;
  endfunction

  task automatic rand_if(input bit allow_mis);
    if_req  = 1'b1;
    if_addr = rand_addr(allow_mis);
  endtask

  task automatic rand_d(input bit allow_mis);
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = rand_addr(allow_mis);
    d_wdata = $urandom;
  endtask

  task automatic chk_stall(input bit ifa, input bit da);
    chk("stall_if", stall_if, if_req & ~ifa);
    chk("stall_mem", stall_mem, d_req & ~da);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_d_ack"}, d_ack, 0);
    chk({tag, "_if_err"}, if_err, 0);
    chk({tag, "_d_err"}, d_err, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // One IDLE cycle: no memory activity, no acks.
  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_mem_req", mem_req, 0);
    chk("idle_if_ack", if_ack, 0);
    chk("idle_d_ack", d_ack, 0);
    chk_stall(0, 0);
  endtask

  // Called at a negedge while the DUT is IDLE with the requests that the
  // next edge will see. Returns at the negedge of the ack cycle with the
  // owner's request withdrawn.
  task automatic txn(input int lat_in, input bit raise, input bit scramble, output bit won_d);
    bit          wd, ewe, mis;
    logic [31:0] ea, ewd, erd;
    int          lat;
    wd = d_req && (!if_req || mcnt < SMAX);
    if (wd) begin
      if (if_req && mcnt < SMAX) mcnt++;
      ea = d_addr; ewe = d_we; ewd = d_wdata;
    end else begin
      mcnt = 0;
      ea = if_addr; ewe = 1'b0; ewd = 32'h0;
    end
    mis = (ea[1:0] != 2'b00);
    lat = (lat_in < 0) ? $urandom_range(0, 4) : lat_in;
    if (!mis) begin
      for (int k = 0; k <= lat; k++) begin
        @(negedge clk);
        chk("busy_mem_req", mem_req, 1);
        chk("busy_mem_we", mem_we, ewe);
        chk("busy_mem_addr", mem_addr, ea);
        chk("busy_mem_wdata", mem_wdata, ewd);
        chk("busy_if_ack", if_ack, 0);
        chk("busy_d_ack", d_ack, 0);
        chk_stall(0, 0);
        if (scramble) begin
          if (wd) begin d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we; end
          else if_addr = $urandom;
        end
        if (raise && k == 0 && $urandom_range(0, 1) == 1) begin
          if (wd && !if_req) rand_if(1);
          else if (!wd && !d_req) rand_d(1);
        end
        if (k == lat) begin
          mem_ready = 1'b1;
          mem_rdata = memarr[mem_addr[5:2]];
          if (mem_we) memarr[mem_addr[5:2]] = mem_wdata;
        end
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    erd = ewe ? 32'h0 : shadow[ea[5:2]];
    if (!mis) begin
      if (ewe) shadow[ea[5:2]] = ewd;
      if (wd) exp_dr = erd; else exp_ifr = erd;
    end
    chk("ack_if_ack", if_ack, !wd);
    chk("ack_d_ack", d_ack, wd);
    chk("ack_if_err", if_err, !wd && mis);
    chk("ack_d_err", d_err, wd && mis);
    chk("ack_mem_req", mem_req, 0);
    chk("ack_if_rdata", if_rdata, exp_ifr);
    chk("ack_d_rdata", d_rdata, exp_dr);
    chk_stall(!wd, wd);
    if (wd) d_req = 1'b0; else if_req = 1'b0;
    won_d = wd;
  endtask

  task automatic drain();
    bit w;
    for (int i = 0; i < 4 && (if_req || d_req); i++) begin
      txn(0, 0, 0, w);
      idle_cycle();
    end
  endtask

  // IF held, data re-requested after every ack: D D D IF repeating.
  task automatic starve_seq(input string tag);
    bit w;
    for (int i = 0; i < 8; i++) begin
      if (!if_req) begin if_req = 1'b1; if_addr = rand_addr(0); end
      if (!d_req) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = rand_addr(0); d_wdata = $urandom;
      end
      txn(-1, 0, 0, w);
      chk(tag, w, (i % 4) != 3);
      idle_cycle();
    end
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    mcnt = 0; exp_ifr = 0; exp_dr = 0;
    for (int i = 0; i < 16; i++) begin memarr[i] = $urandom; shadow[i] = memarr[i]; end
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    chk_stall(0, 0);
    reset = 1'b0;

    // Single IF read.
    memarr[0] = 32'h3C010001; shadow[0] = 32'h3C010001;
    if_req = 1'b1; if_addr = 32'h0000_3000;
    txn(0, 0, 0, w);
    chk("t1_if_won", w, 0);
    chk("t1_if_rdata", if_rdata, 32'h3C010001);
    idle_cycle();

    // Conflict: data store first, then IF.
    if_req = 1'b1; if_addr = 32'h0000_3000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    txn(1, 0, 0, w);
    chk("t2_d_first", w, 1);
    chk("t2_d_rdata", d_rdata, 0);
    idle_cycle();
    txn(0, 0, 0, w);
    chk("t2_if_next", w, 0);
    idle_cycle();

    // Starvation bound.
    starve_seq("t3_owner");

    // Misaligned data access.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h12; d_wdata = 32'h0;
    txn(0, 0, 0, w);
    chk("t4_d_err", d_err, 1);
    idle_cycle();

    // Slow memory with requester inputs changing underneath.
    d_req = 1'b1; d_we = 1'b1; d_addr = rand_addr(0); d_wdata = $urandom;
    txn(5, 0, 1, w);
    chk("t5_d_won", w, 1);
    idle_cycle();

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      if (!if_req && !d_req) begin
        repeat ($urandom_range(0, 2)) idle_cycle();
      end
      case ($urandom_range(0, 3))
        0: if (!if_req) rand_if(1);
        1: if (!d_req) rand_d(1);
        2: begin if (!if_req) rand_if(1); if (!d_req) rand_d(1); end
        default: ;
      endcase
      if (!if_req && !d_req) rand_d(1);
      txn(-1, 1, 1'($urandom_range(0, 1)), w);
      idle_cycle();
    end
    drain();

    // Reset in BUSY with a nonzero starve count, then a stray mem_ready.
    if_req = 1'b1; if_addr = rand_addr(0);
    d_req = 1'b1; d_we = 1'b0; d_addr = rand_addr(0);
    txn(0, 0, 0, w);
    chk("t6_pre_d", w, 1);
    idle_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = $urandom;
    @(negedge clk);
    chk("t6_busy_mem_req", mem_req, 1);
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk_reset_vals("t6_rst");
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_ready = 1'b0;
    chk_reset_vals("t6_after");
    mcnt = 0; exp_ifr = 0; exp_dr = 0;
    repeat (3) idle_cycle();
    starve_seq("t6_starve_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
